// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit read path: timing defaults,
// FSM state encodings and the busy-flag bit position.
package lcd_pkg;

  localparam int T_AS = 3;
  localparam int T_PW = 13;
  localparam int T_EL = 13;

  localparam logic [15:0] POLL_MAX_DEFAULT = 16'd50000;

  localparam int LCD_BF_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HI1,
    E_LO1,
    E_HI2,
    E_LO2,
    CHECK
  } lcd_rd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_HI,
    PH_LO
  } lcd_strobe_phase_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_e_strobe.sv
// One optional-setup / E-high / E-low sequence on a single shared down-counter.
// A start during the last E-low cycle chains straight into the next E-high.
module lcd_e_strobe
  import lcd_pkg::*;
#(
  parameter int T_AS = lcd_pkg::T_AS,
  parameter int T_PW = lcd_pkg::T_PW,
  parameter int T_EL = lcd_pkg::T_EL
) (
  input  logic CLK,
  input  logic reset,
  input  logic start_i,
  input  logic setup_i,
  output logic lcd_e_o,
  output logic setupDone_o,
  output logic sample_o,
  output logic done_o
);

  localparam int CNT_MAX = maxOf3(T_AS, T_PW, T_EL);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_AS = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_PW = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_EL = CNT_W'(T_EL - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  lcd_strobe_phase_t phase_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              e_q;

  lcd_strobe_phase_t loadPhase_d;
  logic [CNT_W-1:0]  loadCnt_d;
  logic              loadE_d;
  logic              last;

  assign last = (cnt_q == '0);

  always_comb begin
    loadPhase_d = PH_HI;
    loadCnt_d   = LD_PW;
    loadE_d     = 1'b1;
    if (setup_i) begin
      loadPhase_d = PH_SETUP;
      loadCnt_d   = LD_AS;
      loadE_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (start_i) begin
            phase_q <= loadPhase_d;
            cnt_q   <= loadCnt_d;
            e_q     <= loadE_d;
          end
        end
        PH_SETUP: begin
          if (last) begin
            phase_q <= PH_HI;
            cnt_q   <= LD_PW;
            e_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        PH_HI: begin
          if (last) begin
            phase_q <= PH_LO;
            cnt_q   <= LD_EL;
            e_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        PH_LO: begin
          if (last) begin
            if (start_i) begin
              phase_q <= loadPhase_d;
              cnt_q   <= loadCnt_d;
              e_q     <= loadE_d;
            end else begin
              phase_q <= PH_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
      endcase
    end
  end

  assign lcd_e_o     = e_q;
  assign setupDone_o = (phase_q == PH_SETUP) && last;
  assign sample_o    = (phase_q == PH_HI) && last;
  assign done_o      = (phase_q == PH_LO) && last;

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read engine: single register/RAM reads and busy-flag polling
// with a bounded retry count. Never drives the data pins.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int          T_AS     = lcd_pkg::T_AS,
  parameter int          T_PW     = lcd_pkg::T_PW,
  parameter int          T_EL     = lcd_pkg::T_EL,
  parameter logic [15:0] POLL_MAX = lcd_pkg::POLL_MAX_DEFAULT
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req_read,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  input  logic [3:0] LCD_D_in
);

  lcd_rd_state_t state_q;
  logic          pollMode_q;
  logic [15:0]   pollCnt_q;
  logic [7:0]    shadow_q;
  logic [7:0]    rdData_q;
  logic          rdValid_q;
  logic          busyTimeout_q;
  logic          ready_q;
  logic          rs_q;
  logic          rw_q;

  logic          strobeStart_d;
  logic          strobeSetup_d;
  logic          retry_d;
  logic [16:0]   pollNext_d;
  logic          setupDone;
  logic          sample;
  logic          done;

  lcd_e_strobe #(
    .T_AS(T_AS),
    .T_PW(T_PW),
    .T_EL(T_EL)
  ) u_strobe (
    .CLK        (CLK),
    .reset      (reset),
    .start_i    (strobeStart_d),
    .setup_i    (strobeSetup_d),
    .lcd_e_o    (LCD_E),
    .setupDone_o(setupDone),
    .sample_o   (sample),
    .done_o     (done)
  );

  // The count is the number of status reads already finished, so POLL_MAX reads happen in total.
  assign pollNext_d = {1'b0, pollCnt_q} + 17'd1;
  assign retry_d    = pollMode_q && shadow_q[LCD_BF_BIT] && (pollNext_d < {1'b0, POLL_MAX});

  always_comb begin
    strobeStart_d = 1'b0;
    strobeSetup_d = 1'b1;
    case (state_q)
      IDLE:    strobeStart_d = req_poll || req_read;
      E_LO1: begin
        strobeStart_d = done;
        strobeSetup_d = 1'b0;
      end
      CHECK:   strobeStart_d = retry_d;
      default: strobeStart_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= IDLE;
      pollMode_q    <= 1'b0;
      pollCnt_q     <= '0;
      shadow_q      <= '0;
      rdData_q      <= '0;
      rdValid_q     <= 1'b0;
      busyTimeout_q <= 1'b0;
      ready_q       <= 1'b1;
      rs_q          <= 1'b0;
      rw_q          <= 1'b0;
    end else begin
      rdValid_q     <= 1'b0;
      busyTimeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_poll || req_read) begin
            pollMode_q <= req_poll;
            rs_q       <= req_poll ? 1'b0 : req_rs;
            pollCnt_q  <= '0;
            ready_q    <= 1'b0;
            rw_q       <= 1'b1;
            state_q    <= SETUP;
          end
        end
        SETUP: if (setupDone) state_q <= E_HI1;
        E_HI1: begin
          if (sample) begin
            shadow_q[7:4] <= LCD_D_in;
            state_q       <= E_LO1;
          end
        end
        E_LO1: if (done) state_q <= E_HI2;
        E_HI2: begin
          if (sample) begin
            shadow_q[3:0] <= LCD_D_in;
            state_q       <= E_LO2;
          end
        end
        E_LO2: if (done) state_q <= CHECK;
        CHECK: begin
          if (retry_d) begin
            pollCnt_q <= pollNext_d[15:0];
            state_q   <= SETUP;
          end else begin
            rdData_q <= shadow_q;
            if (pollMode_q && shadow_q[LCD_BF_BIT]) begin
              busyTimeout_q <= 1'b1;
            end else begin
              rdValid_q <= 1'b1;
            end
            ready_q <= 1'b1;
            rw_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready        = ready_q;
  assign rd_valid     = rdValid_q;
  assign rd_data      = rdData_q;
  assign busy_timeout = busyTimeout_q;
  assign LCD_RS       = rs_q;
  assign LCD_RW       = rw_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: table of read/poll transactions against
// a nibble-serving LCD model, plus contention, back-to-back and reset sequences.
module tb_lcd_reader;

  localparam int TXN     = 56;
  localparam int MAX_CYC = 1000;

  logic       CLK = 1'b0;
  logic       reset;
  logic       req_read, req_rs, req_poll;
  logic       ready, rd_valid, busy_timeout;
  logic [7:0] rd_data;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [3:0] lcdD;

  int errors = 0;
  int checks = 0;

  logic [7:0] respBytes [8];
  int         readIdx;
  int         nibIdx;
  logic       prevE;

  typedef struct {
    logic        rd;
    logic        rs;
    logic        poll;
    logic [31:0] resp;
    int          nResp;
    logic [7:0]  expData;
    int          expCyc;
    logic        expValid;
    logic        expTo;
    logic        expRs;
    int          expPulses;
  } vec_t;

  vec_t vecs [7];

  lcd_reader #(.POLL_MAX(16'd4)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .req_read    (req_read),
    .req_rs      (req_rs),
    .req_poll    (req_poll),
    .ready       (ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .busy_timeout(busy_timeout),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_D_in    (lcdD)
  );

  always #5 CLK = ~CLK;

  // LCD model: high nibble until the first E falls, then low nibble, then next byte.
  always @(posedge CLK) begin
    #1;
    if (prevE && !LCD_E) begin
      if (nibIdx == 1) begin
        nibIdx = 0;
        if (readIdx < 7) readIdx = readIdx + 1;
      end else begin
        nibIdx = 1;
      end
    end
    prevE = LCD_E;
    lcdD  = (nibIdx == 0) ? respBytes[readIdx][7:4] : respBytes[readIdx][3:0];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic setResponses(input logic [31:0] w, input int n);
    for (int i = 0; i < 8; i++) begin
      if (i < n) respBytes[i] = w[31-8*i -: 8];
      else       respBytes[i] = w[31-8*(n-1) -: 8];
    end
    readIdx = 0;
    nibIdx  = 0;
    prevE   = 1'b0;
    lcdD    = respBytes[0][7:4];
  endtask

  task automatic applyStimulus(
    input  logic rd, input logic rs, input logic poll,
    input  int injCyc, input logic injRd, input logic injRs, input logic injPoll,
    input  logic expRs,
    output int cyc, output int pulses, output int badPulse, output int protoBad,
    output logic v, output logic to, output logic [7:0] data,
    output logic readyAt, output logic rwAt, output logic finished);
    int hiRun;
    v = 1'b0; to = 1'b0; data = 8'h00; readyAt = 1'b0; rwAt = 1'b1;
    @(negedge CLK);
    req_read = rd; req_rs = rs; req_poll = poll;
    @(posedge CLK);
    cyc = 0; hiRun = 0; pulses = 0; badPulse = 0; protoBad = 0; finished = 1'b0;
    while (cyc < MAX_CYC && !finished) begin
      @(negedge CLK);
      if (cyc == 0) begin req_read = 1'b0; req_rs = 1'b0; req_poll = 1'b0; end
      if (cyc == injCyc) begin req_read = injRd; req_rs = injRs; req_poll = injPoll; end
      else if (cyc == injCyc + 1) begin req_read = 1'b0; req_rs = 1'b0; req_poll = 1'b0; end
      if (rd_valid || busy_timeout) begin
        finished = 1'b1;
        v = rd_valid; to = busy_timeout; data = rd_data;
        readyAt = ready; rwAt = LCD_RW;
      end else begin
        if (LCD_E) hiRun++;
        else if (hiRun > 0) begin
          pulses++;
          if (hiRun != 13) badPulse++;
          hiRun = 0;
        end
        if (LCD_RS !== expRs || LCD_RW !== 1'b1 || ready !== 1'b0) protoBad++;
        cyc++;
      end
    end
    req_read = 1'b0; req_rs = 1'b0; req_poll = 1'b0;
  endtask

  initial begin
    int cyc, pulses, badPulse, protoBad, activity, firstCyc, secondCyc, nValid;
    logic v, to, readyAt, rwAt, finished;
    logic [7:0] data, data1, data2;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h35000000, 1, 8'h35, TXN,     1'b1, 1'b0, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hAC000000, 1, 8'hAC, TXN,     1'b1, 1'b0, 1'b1, 2};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'hFF000000, 1, 8'hFF, TXN,     1'b1, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h9A80C127, 4, 8'h27, 4 * TXN, 1'b1, 1'b0, 1'b0, 8};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h80808080, 4, 8'h80, 4 * TXN, 1'b0, 1'b1, 1'b0, 8};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h85120000, 2, 8'h12, 2 * TXN, 1'b1, 1'b0, 1'b0, 4};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 1, 8'h00, TXN,     1'b1, 1'b0, 1'b0, 2};

    reset = 1'b1; req_read = 1'b0; req_rs = 1'b0; req_poll = 1'b0;
    setResponses(32'h0, 1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_busy_timeout", 32'(busy_timeout), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'h00);
    checkOutput("reset_lcd_e", 32'(LCD_E), 32'd0);
    checkOutput("reset_lcd_rs", 32'(LCD_RS), 32'd0);
    checkOutput("reset_lcd_rw", 32'(LCD_RW), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      setResponses(vecs[k].resp, vecs[k].nResp);
      applyStimulus(vecs[k].rd, vecs[k].rs, vecs[k].poll, -10, 1'b0, 1'b0, 1'b0, vecs[k].expRs,
                    cyc, pulses, badPulse, protoBad, v, to, data, readyAt, rwAt, finished);
      $display("[TB] vector %0d done after %0d cycles", k, cyc);
      checkOutput($sformatf("v%0d_finished", k), 32'(finished), 32'd1);
      checkOutput($sformatf("v%0d_latency", k), 32'(cyc), 32'(vecs[k].expCyc));
      checkOutput($sformatf("v%0d_rd_valid", k), 32'(v), 32'(vecs[k].expValid));
      checkOutput($sformatf("v%0d_busy_timeout", k), 32'(to), 32'(vecs[k].expTo));
      checkOutput($sformatf("v%0d_rd_data", k), 32'(data), 32'(vecs[k].expData));
      checkOutput($sformatf("v%0d_ready_at_done", k), 32'(readyAt), 32'd1);
      checkOutput($sformatf("v%0d_rw_at_done", k), 32'(rwAt), 32'd0);
      checkOutput($sformatf("v%0d_e_pulses", k), 32'(pulses), 32'(vecs[k].expPulses));
      checkOutput($sformatf("v%0d_e_width_errs", k), 32'(badPulse), 32'd0);
      checkOutput($sformatf("v%0d_rs_rw_ready_errs", k), 32'(protoBad), 32'd0);
      @(negedge CLK);
      checkOutput($sformatf("v%0d_pulse_len", k), {30'd0, rd_valid, busy_timeout}, 32'd0);
      checkOutput($sformatf("v%0d_rd_data_held", k), 32'(rd_data), 32'(vecs[k].expData));
    end

    // Requests arriving mid-transaction must be dropped, not queued.
    setResponses(32'h35000000, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 20, 1'b1, 1'b1, 1'b1, 1'b0,
                  cyc, pulses, badPulse, protoBad, v, to, data, readyAt, rwAt, finished);
    checkOutput("ignore_latency", 32'(cyc), 32'(TXN));
    checkOutput("ignore_rd_data", 32'(data), 32'h35);
    checkOutput("ignore_rs_rw_ready_errs", 32'(protoBad), 32'd0);
    activity = 0;
    repeat (70) begin
      @(negedge CLK);
      if (LCD_E || !ready || LCD_RW || rd_valid || busy_timeout) activity++;
    end
    checkOutput("ignore_no_queued_txn", 32'(activity), 32'd0);

    // Request held high: second acceptance one edge after ready returns.
    setResponses(32'h11220000, 2);
    @(negedge CLK);
    req_read = 1'b1; req_rs = 1'b1;
    @(posedge CLK);
    cyc = 0; nValid = 0; firstCyc = -1; secondCyc = -1; data1 = 8'h00; data2 = 8'h00;
    while (cyc < 300 && nValid < 2) begin
      @(negedge CLK);
      if (rd_valid) begin
        nValid++;
        if (nValid == 1) begin firstCyc = cyc; data1 = rd_data; end
        else begin secondCyc = cyc; data2 = rd_data; req_read = 1'b0; req_rs = 1'b0; end
      end
      if (nValid < 2) cyc++;
    end
    req_read = 1'b0; req_rs = 1'b0;
    checkOutput("b2b_first_latency", 32'(firstCyc), 32'(TXN));
    checkOutput("b2b_first_data", 32'(data1), 32'h11);
    checkOutput("b2b_second_latency", 32'(secondCyc), 32'(2 * TXN + 1));
    checkOutput("b2b_second_data", 32'(data2), 32'h22);
    activity = 0;
    repeat (10) begin
      @(negedge CLK);
      if (!ready || LCD_E) activity++;
    end
    checkOutput("b2b_no_third_txn", 32'(activity), 32'd0);

    // Reset in the middle of the second E-high strobe.
    setResponses(32'h35000000, 1);
    @(negedge CLK);
    req_read = 1'b1; req_rs = 1'b0;
    @(posedge CLK);
    for (int c = 0; c <= 35; c++) begin
      @(negedge CLK);
      req_read = 1'b0;
    end
    checkOutput("rst_mid_e_high", 32'(LCD_E), 32'd1);
    reset = 1'b1;
    @(negedge CLK);
    checkOutput("rst_mid_lcd_e", 32'(LCD_E), 32'd0);
    checkOutput("rst_mid_ready", 32'(ready), 32'd1);
    checkOutput("rst_mid_lcd_rw", 32'(LCD_RW), 32'd0);
    checkOutput("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    activity = 0;
    repeat (80) begin
      @(negedge CLK);
      if (rd_valid || busy_timeout || LCD_E) activity++;
    end
    checkOutput("rst_mid_no_completion", 32'(activity), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side transaction engine for the HD44780 character LCD in 4-bit mode, complementing the existing write/init path. On request it drives RS/RW, strobes E twice, and assembles the high and low nibbles into one byte (status or DDRAM/CGRAM data). It also offers a busy-flag poll mode with a timeout. The block sits beside the LCD write path in the top level. It never drives the data pins; bus direction and arbitration live in the top level.

## Interface
- T_AS, 3: cycles RS/RW held before E rises (≥40 ns at 50 MHz)
- T_PW, 13: cycles E held high per nibble (≥230 ns)
- T_EL, 13: cycles E held low after each nibble (cycle ≥500 ns)
- POLL_MAX, 16'd50000: maximum status reads in poll mode before timeout
- CLK  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- req_read  in  1  start one read; RS taken from req_rs
- req_rs  in  1  0 = status/address register, 1 = data RAM
- req_poll  in  1  start busy poll (RS forced 0)
- ready  out  1  high when idle and able to accept a request
- rd_valid  out  1  one-cycle pulse; rd_data valid
- rd_data  out  8  assembled byte, held until next rd_valid
- busy_timeout  out  1  one-cycle pulse; poll gave up
- LCD_E  out  1  enable strobe
- LCD_RS  out  1  register select
- LCD_RW  out  1  1 = read; 0 whenever idle
- LCD_D_in  in  4  data bus D7..D4 as seen at the pins

## Operation
- States: IDLE, SETUP, E_HI1, E_LO1, E_HI2, E_LO2, CHECK.
- IDLE: ready=1, LCD_RW=0, LCD_E=0. The block samples requests only here.
  - If req_poll=1, the block enters poll mode; this takes precedence over a simultaneous req_read.
  - Otherwise, if req_read=1, the block latches req_rs.
  - On acceptance: ready→0, LCD_RW→1, LCD_RS set, next state SETUP.
- SETUP: lasts T_AS cycles, then E_HI1 (LCD_E=1).
- E_HI1: lasts T_PW cycles. In its last cycle the block registers LCD_D_in into rd_data[7:4] (shadow register). It then moves to E_LO1 (LCD_E=0).
- E_LO1: lasts T_EL cycles, then E_HI2.
- E_HI2: same as E_HI1; its last cycle captures rd_data[3:0].
- E_LO2: lasts T_EL cycles, then CHECK.
- CHECK, single read: rd_data updates and rd_valid pulses. The block returns to IDLE with LCD_RW=0 and ready=1.
- CHECK, poll mode:
  - If byte[7]=0 (not busy): rd_valid pulses with the byte (BF=0, AC in [6:0]), then IDLE.
  - If byte[7]=1 and the poll count is below POLL_MAX: count+1, back to SETUP with RS and RW kept. There is no rd_valid pulse.
  - If the count reaches POLL_MAX: busy_timeout pulses, rd_data takes the last status byte, then IDLE.
- The poll counter is 16 bits and clears on each new poll request. It never wraps.
- Requests received while ready=0 are ignored. They are not queued.

## Timing
- Reset values: ready=1, rd_valid=0, busy_timeout=0, rd_data=8'h00, LCD_E=0, LCD_RS=0, LCD_RW=0; state IDLE, poll count 0.
- Reset asserted mid-transaction takes effect at the next edge. E drops immediately, with no completion pulse.
- Single read latency: rd_valid is high in the cycle beginning T_AS+2·T_PW+2·T_EL+1 edges after the accepting edge. With defaults this is 56.
- ready returns to 1 in the same cycle as rd_valid. A new request is accepted on the following edge at the earliest.
- Each further poll iteration adds T_AS+2·T_PW+2·T_EL+1 cycles.
- rd_valid and busy_timeout are never high in the same cycle.

## Structure
- Package lcd_pkg holds:
  - the state enum lcd_rd_state_t;
  - timing defaults (T_AS, T_PW, T_EL) shared with the write path;
  - the constant LCD_BF_BIT = 7.
- One natural sub-module, lcd_e_strobe: given start, it produces one setup/E-high/E-low sequence with a sample strobe at the last E-high cycle, and is reused for both nibbles.
- A single down-counter, sized for max(T_AS, T_PW, T_EL), serves all timed states.

## Test plan
- Status read: req_read=1, req_rs=0; the model drives 4'h3 then 4'h5. Expect rd_data=8'h35 and rd_valid exactly 56 cycles later; RS=0 and RW=1 throughout; E high for exactly 13 cycles twice.
- Data read: req_rs=1, nibbles A then C. Expect rd_data=8'hAC and LCD_RS=1 during the transaction; LCD_RW=0 after completion.
- Poll success: BF=1 for 3 reads, then status 8'h27. Expect a single rd_valid with 8'h27 after 4×56 cycles and no busy_timeout.
- Poll timeout: POLL_MAX=4 and BF stuck at 1 (8'h80). Expect a busy_timeout pulse after 4 reads, no rd_valid, and rd_data=8'h80.
- Contention and reset: req_read and req_poll in the same cycle, so poll mode is taken. A req_read mid-transaction is ignored. A reset asserted in E_HI2 gives LCD_E=0 and ready=1 on the next edge, with no rd_valid.
